// File: rtl/pcpu_pkg.sv
// Shared defaults, width helpers and typedefs for the pcpu register file and scoreboard.
package pcpu_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int NREGS_DEF    = 8;
    localparam int NRD_DEF      = 2;
    localparam int MAX_INFL_DEF = 3;

    // A single-register file still needs a one-bit address.
    function automatic int addr_w(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    localparam int ADDR_W = addr_w(NREGS_DEF);
    localparam int CW     = $clog2(MAX_INFL_DEF + 1);

    typedef logic [ADDR_W-1:0]     reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/pcpu_sb_counter.sv
// In-flight write counter for one register: net-sums issue, retire and cancel each edge,
// saturating at 0 on underflow and flagging it.
module pcpu_sb_counter
    import pcpu_pkg::*;
#(
    parameter  int MAX_INFL = MAX_INFL_DEF,
    localparam int CW       = $clog2(MAX_INFL + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec_wb,
    input  logic          dec_cnl,
    output logic [CW-1:0] cnt,
    output logic          nz,
    output logic          at_max,
    output logic          underflow
);

    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic signed [CW+1:0] sum;

    always_comb begin
        sum = $signed({2'b00, cnt_q})
            + $signed({{(CW + 1){1'b0}}, inc})
            - $signed({{(CW + 1){1'b0}}, dec_wb})
            - $signed({{(CW + 1){1'b0}}, dec_cnl});
        underflow = sum[CW+1];
        // Admission control keeps sum <= MAX_INFL; the high clamp only guards misuse.
        if (underflow) begin
            cnt_d = '0;
        end else if (sum[CW]) begin
            cnt_d = '1;
        end else begin
            cnt_d = sum[CW-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign nz     = (cnt_q != '0);
    assign at_max = (cnt_q >= CW'(MAX_INFL));

endmodule

// File: rtl/pcpu_regfile_sb.sv
// Register file with per-register in-flight scoreboard and indexed debug read.
// Optional write-back bypass on reads and busy flags: define RF_BYPASS_EN.
module pcpu_regfile_sb
    import pcpu_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int NREGS    = NREGS_DEF,
    parameter  int NRD      = NRD_DEF,
    parameter  int MAX_INFL = MAX_INFL_DEF,
    localparam int ADDR_W   = addr_w(NREGS),
    localparam int CW       = $clog2(MAX_INFL + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  iss_valid,
    input  logic [ADDR_W-1:0]     iss_addr,
    output logic                  iss_ready,
    input  logic                  cnl_valid,
    input  logic [ADDR_W-1:0]     cnl_addr,
    input  logic                  wb_valid,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic [ADDR_W-1:0]     dbg_addr,
    output logic [DATA_W-1:0]     dbg_data,
    output logic                  any_busy,
    output logic                  err
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              err_q;
    logic              err_d;

    logic [CW-1:0]     cnt [NREGS];
    logic [NREGS-1:0]  inc;
    logic [NREGS-1:0]  dec_wb;
    logic [NREGS-1:0]  dec_cnl;
    logic [NREGS-1:0]  nz;
    logic [NREGS-1:0]  at_max;
    logic [NREGS-1:0]  underflow;
    logic              wb_in;
    logic              cnl_in;
    logic              iss_in;
    logic              iss_acc;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < (ADDR_W + 1)'(NREGS));
    endfunction

    function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] d;
        d = '0;
        if (in_range(a)) begin
            d = regs_q[a];
`ifdef RF_BYPASS_EN
            if (wb_valid && wb_addr == a) begin
                d = wb_data;
            end
`endif
        end
        return d;
    endfunction

    function automatic logic read_busy(input logic [ADDR_W-1:0] a);
        logic b;
        b = 1'b0;
        if (in_range(a)) begin
            b = nz[a];
`ifdef RF_BYPASS_EN
            // The last outstanding write retires now, unless a fresh issue re-arms it.
            if (wb_valid && wb_addr == a && cnt[a] == CW'(1) && !inc[a]) begin
                b = 1'b0;
            end
`endif
        end
        return b;
    endfunction

    always_comb begin
        wb_in  = in_range(wb_addr);
        cnl_in = in_range(cnl_addr);
        iss_in = in_range(iss_addr);

        // A retire or cancel to the same register frees a slot within this cycle.
        iss_ready = !(iss_in && at_max[iss_addr])
                  || (wb_valid && wb_addr == iss_addr)
                  || (cnl_valid && cnl_addr == iss_addr);
        iss_acc   = iss_valid && iss_ready && iss_in;

        inc      = '0;
        dec_wb   = '0;
        dec_cnl  = '0;
        any_busy = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            inc[r]     = iss_acc && (iss_addr == ADDR_W'(r));
            dec_wb[r]  = wb_valid && (wb_addr == ADDR_W'(r));
            dec_cnl[r] = cnl_valid && (cnl_addr == ADDR_W'(r));
            any_busy   = any_busy | (cnt[r] != '0);
        end

        err_d = err_q
              | (wb_valid && !wb_in)
              | (cnl_valid && !cnl_in)
              | (iss_valid && !iss_in)
              | (|underflow);

        regs_d = regs_q;
        if (wb_valid && wb_in) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            regs_q <= '{default: '0};
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            err_q  <= err_d;
        end
    end

    for (genvar r = 0; r < NREGS; r++) begin : g_cnt
        pcpu_sb_counter #(
            .MAX_INFL (MAX_INFL)
        ) u_cnt (
            .clock     (clock),
            .reset     (reset),
            .inc       (inc[r]),
            .dec_wb    (dec_wb[r]),
            .dec_cnl   (dec_cnl[r]),
            .cnt       (cnt[r]),
            .nz        (nz[r]),
            .at_max    (at_max[r]),
            .underflow (underflow[r])
        );
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_data[i*DATA_W +: DATA_W] = read_data(rd_addr[i*ADDR_W +: ADDR_W]);
            rd_busy[i]                  = read_busy(rd_addr[i*ADDR_W +: ADDR_W]);
        end
        dbg_data = read_data(dbg_addr);
    end

    assign err = err_q;

endmodule

// File: tb/tb_pcpu_regfile_sb.sv
// Scoreboard bench for pcpu_regfile_sb: a default 8-register instance plus a 6-register
// instance for out-of-range addresses.
module tb_pcpu_regfile_sb;
    import pcpu_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    reg_addr_t          ra0, ra1, iss_addr, cnl_addr, wb_addr, dbg_addr;
    logic               iss_valid, cnl_valid, wb_valid;
    reg_data_t          wb_data;
    logic [2*ADDR_W-1:0] rd_addr;
    logic [31:0]        rd_data;
    logic [1:0]         rd_busy;
    logic               iss_ready, any_busy, err;
    reg_data_t          dbg_data;

    logic [2:0]         b_wb_addr, b_dbg_addr;
    logic               b_wb_valid;
    logic [5:0]         b_rd_addr;
    logic [31:0]        b_rd_data;
    logic [1:0]         b_rd_busy;
    logic               b_iss_ready, b_any_busy, b_err;
    reg_data_t          b_dbg_data;

    assign rd_addr = {ra1, ra0};

    pcpu_regfile_sb dut (
        .clock(clock), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
        .cnl_valid(cnl_valid), .cnl_addr(cnl_addr),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .any_busy(any_busy), .err(err)
    );

    pcpu_regfile_sb #(.NREGS(6)) dut6 (
        .clock(clock), .reset(reset),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .iss_valid(1'b0), .iss_addr(3'd0), .iss_ready(b_iss_ready),
        .cnl_valid(1'b0), .cnl_addr(3'd0),
        .wb_valid(b_wb_valid), .wb_addr(b_wb_addr), .wb_data(16'hFFFF),
        .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data),
        .any_busy(b_any_busy), .err(b_err)
    );

    typedef enum int {P_RD0, P_BSY0, P_RD1, P_BSY1, P_DBG, P_ANY, P_ERR, P_RDY,
                      P_ERR6, P_DBG6, P_RD6, P_BSY6} probe_e;
    typedef struct {
        string       tag;
        probe_e      sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_mis = 0;

    function automatic logic [31:0] probe(input probe_e s);
        case (s)
            P_RD0:   return {16'h0, rd_data[15:0]};
            P_BSY0:  return {31'h0, rd_busy[0]};
            P_RD1:   return {16'h0, rd_data[31:16]};
            P_BSY1:  return {31'h0, rd_busy[1]};
            P_DBG:   return {16'h0, dbg_data};
            P_ANY:   return {31'h0, any_busy};
            P_ERR:   return {31'h0, err};
            P_RDY:   return {31'h0, iss_ready};
            P_ERR6:  return {31'h0, b_err};
            P_DBG6:  return {16'h0, b_dbg_data};
            P_RD6:   return {16'h0, b_rd_data[15:0]};
            P_BSY6:  return {31'h0, b_rd_busy[0]};
            default: return 32'hDEAD_DEAD;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input probe_e sel, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.sel = sel;
        x.exp = e;
        sb.push_back(x);
    endtask

    // Let combinational outputs settle, then retire every queued expectation.
    task automatic drain();
        exp_t x;
        #1;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            chk(x.tag, probe(x.sel), x.exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        iss_valid  = 1'b0;
        cnl_valid  = 1'b0;
        wb_valid   = 1'b0;
        b_wb_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        ra0 = '0; ra1 = '0; dbg_addr = '0;
        iss_addr = '0; cnl_addr = '0; wb_addr = '0; wb_data = '0;
        b_wb_addr = '0; b_dbg_addr = '0; b_rd_addr = '0;
        idle();
        tick();
        do_reset();

        // Reset state
        push_exp("rst_busy0", P_BSY0, 0);
        push_exp("rst_any",   P_ANY,  0);
        push_exp("rst_ready", P_RDY,  1);
        push_exp("rst_rd0",   P_RD0,  0);
        push_exp("rst_dbg",   P_DBG,  0);
        push_exp("rst_err",   P_ERR,  0);
        push_exp("rst_err6",  P_ERR6, 0);
        drain();

        // Plain write then read; a write with no issue underflows and sets err
        wb_valid = 1'b1; wb_addr = 3'd3; wb_data = 16'hBEEF;
        tick();
        idle();
        ra0 = 3'd3; dbg_addr = 3'd3;
        push_exp("t1_rd0",   P_RD0,  32'hBEEF);
        push_exp("t1_busy0", P_BSY0, 0);
        push_exp("t1_dbg",   P_DBG,  32'hBEEF);
        push_exp("t1_err",   P_ERR,  1);
        drain();
        do_reset();

        // Fill r5 to MAX_INFL, hold a 4th issue, then accept it alongside a retire
        ra0 = 3'd5; iss_addr = 3'd5;
        for (int k = 0; k < 3; k++) begin
            iss_valid = 1'b1;
            push_exp("t2_ready_fill", P_RDY, 1);
            drain();
            tick();
        end
        push_exp("t2_ready_full", P_RDY,  0);
        push_exp("t2_busy_full",  P_BSY0, 1);
        drain();
        tick();
        wb_valid = 1'b1; wb_addr = 3'd5; wb_data = 16'h1234;
        push_exp("t2_ready_wb", P_RDY, 1);
        drain();
        tick();
        idle();
        push_exp("t2_ready_after", P_RDY, 0);
        push_exp("t2_rd0",         P_RD0, 32'h1234);
        drain();
        cnl_addr = 3'd5;
        for (int k = 0; k < 3; k++) begin
            cnl_valid = 1'b1;
            tick();
            cnl_valid = 1'b0;
            push_exp("t2_busy_drain", P_BSY0, (k < 2) ? 32'd1 : 32'd0);
            drain();
        end
        push_exp("t2_err", P_ERR, 0);
        drain();

        // Issue r2, then retire it while port 1 reads r2
        iss_valid = 1'b1; iss_addr = 3'd2; ra1 = 3'd2;
        tick();
        idle();
        push_exp("t3_busy_pre", P_BSY1, 1);
        drain();
        wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 16'h5A5A; dbg_addr = 3'd2;
`ifdef RF_BYPASS_EN
        push_exp("t3_rd1_wb",  P_RD1,  32'h5A5A);
        push_exp("t3_busy_wb", P_BSY1, 0);
        push_exp("t3_dbg_wb",  P_DBG,  32'h5A5A);
`else
        push_exp("t3_rd1_wb",  P_RD1,  0);
        push_exp("t3_busy_wb", P_BSY1, 1);
        push_exp("t3_dbg_wb",  P_DBG,  0);
`endif
        drain();
        tick();
        idle();
        push_exp("t3_busy_next", P_BSY1, 0);
        push_exp("t3_rd1_next",  P_RD1,  32'h5A5A);
        drain();

        // Two issues on r1, then cancel and retire in the same cycle
        ra0 = 3'd1; iss_addr = 3'd1;
        iss_valid = 1'b1;
        tick();
        tick();
        idle();
        cnl_valid = 1'b1; cnl_addr = 3'd1;
        wb_valid = 1'b1; wb_addr = 3'd1; wb_data = 16'h0011;
        tick();
        idle();
        push_exp("t4_any",   P_ANY,  0);
        push_exp("t4_err",   P_ERR,  0);
        push_exp("t4_busy0", P_BSY0, 0);
        push_exp("t4_rd0",   P_RD0,  32'h0011);
        drain();

        // Underflowing write, sticky err, out-of-range write on the 6-register instance
        wb_valid = 1'b1; wb_addr = 3'd4; wb_data = 16'h0444;
        tick();
        idle();
        ra0 = 3'd4;
        push_exp("t5_rd0", P_RD0, 32'h0444);
        push_exp("t5_err", P_ERR, 1);
        drain();
        tick();
        push_exp("t5_err_sticky", P_ERR, 1);
        drain();
        b_wb_valid = 1'b1; b_wb_addr = 3'd7;
        tick();
        idle();
        b_dbg_addr = 3'd7; b_rd_addr = {3'd0, 3'd7};
        push_exp("t5_err6",  P_ERR6, 1);
        push_exp("t5_dbg6",  P_DBG6, 0);
        push_exp("t5_rd6",   P_RD6,  0);
        push_exp("t5_bsy6",  P_BSY6, 0);
        drain();
        do_reset();
        push_exp("t5_err_clr",  P_ERR,  0);
        push_exp("t5_err6_clr", P_ERR6, 0);
        drain();

        // Every counter in flight, then reset while an issue is still offered
        for (int r = 0; r < 8; r++) begin
            iss_valid = 1'b1; iss_addr = 3'(r);
            tick();
        end
        idle();
        ra0 = 3'd7;
        push_exp("t6_any_pre",  P_ANY,  1);
        push_exp("t6_busy_pre", P_BSY0, 1);
        drain();
        reset = 1'b1;
        iss_valid = 1'b1; iss_addr = 3'd6;
        tick();
        reset = 1'b0;
        idle();
        push_exp("t6_any", P_ANY, 0);
        drain();
        for (int r = 0; r < 8; r++) begin
            ra0 = 3'(r); dbg_addr = 3'(r);
            push_exp($sformatf("t6_busy_r%0d", r), P_BSY0, 0);
            push_exp($sformatf("t6_rd_r%0d", r),   P_RD0,  0);
            push_exp($sformatf("t6_dbg_r%0d", r),  P_DBG,  0);
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
